// File: rtl/led_demux.sv
// Recovers six multiplexed 7-segment digits from a scanned segment/select bus.
// A selection must be stable for STABLE_CYC cycles before its pattern is decoded and captured.

module led_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap_i,
  input  logic [4:0] val_i,
  output logic [4:0] out_o,
  output logic       vld_o
);
  logic [4:0] out_q;
  logic       vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else if (cap_i) begin
      out_q <= val_i;
      vld_q <= 1'b1;
    end
  end

  assign out_o = out_q;
  assign vld_o = vld_q;
endmodule

module led_demux #(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic [5:0] sel_in,
  output logic [4:0] out0,
  output logic [4:0] out1,
  output logic [4:0] out2,
  output logic [4:0] out3,
  output logic [4:0] out4,
  output logic [4:0] out5,
  output logic [5:0] valid_mask,
  output logic       frame_done,
  output logic       decode_err
);
  localparam int         NPOS   = 6;
  localparam logic [7:0] STABLE = 8'(STABLE_CYC);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  // Returns {hit, value}; anything outside the table (blank included) is a miss.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40: seg_decode = 5'h10;
      7'h79: seg_decode = 5'h11;
      7'h24: seg_decode = 5'h12;
      7'h30: seg_decode = 5'h13;
      7'h19: seg_decode = 5'h14;
      7'h12: seg_decode = 5'h15;
      7'h02: seg_decode = 5'h16;
      7'h78: seg_decode = 5'h17;
      7'h00: seg_decode = 5'h18;
      7'h10: seg_decode = 5'h19;
      7'h08: seg_decode = 5'h1A;
      7'h03: seg_decode = 5'h1B;
      7'h46: seg_decode = 5'h1C;
      7'h21: seg_decode = 5'h1D;
      7'h06: seg_decode = 5'h1E;
      7'h0E: seg_decode = 5'h1F;
      default: seg_decode = 5'h00;
    endcase
  endfunction

  logic [7:0]            seg_q, lseg_q, lseg_d;
  logic [5:0]            sel_q, lsel_q, lsel_d;
  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [5:0]            frame_q, frame_d;
  logic                  fdone_q, err_q;
  logic                  cap;
  logic [5:0]            sel_act, cap_vec;
  logic                  sel_legal, hit;
  logic [4:0]            dec, dig_val;
  logic [NPOS-1:0][4:0]  dig_out;

  // Active-low one-hot: exactly one cleared bit.
  assign sel_act   = ~sel_q;
  assign sel_legal = (sel_act != '0) && ((sel_act & (sel_act - 6'd1)) == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lsel_d  = lsel_q;
    lseg_d  = lseg_q;
    cap     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (sel_legal) begin
          cnt_d   = 8'd1;
          lsel_d  = sel_q;
          lseg_d  = seg_q;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (sel_q != lsel_q || seg_q != lseg_q) begin
          state_d = ST_WAIT;
        end else begin
          cnt_d = (cnt_q >= STABLE) ? STABLE : cnt_q + 8'd1;
          if (cnt_d == STABLE) begin
            cap     = 1'b1;
            state_d = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (sel_q != lsel_q) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign dec     = seg_decode(lseg_q[6:0]);
  assign hit     = dec[4];
  assign dig_val = {~lseg_q[7], dec[3:0]};
  assign cap_vec = (cap && hit) ? ~lsel_q : 6'd0;

  // A capture landing on the clearing cycle belongs to the new frame.
  assign frame_d = ((&frame_q) ? 6'd0 : frame_q) | cap_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '1;
      sel_q   <= '1;
      lseg_q  <= '1;
      lsel_q  <= '1;
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      frame_q <= '0;
      fdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      seg_q   <= seg_in;
      sel_q   <= sel_in;
      lseg_q  <= lseg_d;
      lsel_q  <= lsel_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      fdone_q <= &frame_q;
      err_q   <= cap & ~hit;
    end
  end

  for (genvar k = 0; k < NPOS; k++) begin : g_dig
    led_digit u_dig (
      .clk   (clk),
      .rst_n (rst_n),
      .cap_i (cap_vec[k]),
      .val_i (dig_val),
      .out_o (dig_out[k]),
      .vld_o (valid_mask[k])
    );
  end

  assign out0       = dig_out[0];
  assign out1       = dig_out[1];
  assign out2       = dig_out[2];
  assign out3       = dig_out[3];
  assign out4       = dig_out[4];
  assign out5       = dig_out[5];
  assign frame_done = fdone_q;
  assign decode_err = err_q;
endmodule

// File: tb/tb_led_demux.sv
// Directed bench for led_demux with STABLE_CYC=4; expected values worked out by hand.

module tb_led_demux;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_in;
  logic [5:0] sel_in;
  logic [4:0] out0, out1, out2, out3, out4, out5;
  logic [5:0] valid_mask;
  logic       frame_done, decode_err;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;
  int de_cnt = 0;
  int fd0;

  led_demux #(.STABLE_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .sel_in     (sel_in),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out5       (out5),
    .valid_mask (valid_mask),
    .frame_done (frame_done),
    .decode_err (decode_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (decode_err) de_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] s, input logic [7:0] g);
    sel_in = s;
    seg_in = g;
  endtask

  function automatic logic [5:0] sel_of(input int k);
    logic [5:0] one;
    one = 6'd1;
    return ~(one << k);
  endfunction

  function automatic logic [4:0] out_of(input int k);
    case (k)
      0: return out0;
      1: return out1;
      2: return out2;
      3: return out3;
      4: return out4;
      default: return out5;
    endcase
  endfunction

  // seg bus with decimal point off: 0..5
  logic [7:0] segs [6] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};

  initial begin
    rst_n = 1'b0;
    drive(6'h3F, 8'hFF);
    #3;
    chk("rst_out0", out0, 5'h00);
    chk("rst_out5", out5, 5'h00);
    chk("rst_vmask", valid_mask, 6'h00);
    chk("rst_fdone", frame_done, 1'b0);
    chk("rst_derr", decode_err, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Three stable cycles is one short of a capture
    drive(6'h3E, 8'h80); tick(3);
    drive(6'h3F, 8'hFF); tick(6);
    chk("short_out0", out0, 5'h00);
    chk("short_vmask", valid_mask, 6'h00);
    chk("short_derr", de_cnt, 0);

    // Blank pattern is a decode miss
    drive(6'h3D, 8'hFF); tick(10);
    drive(6'h3F, 8'hFF); tick(4);
    chk("blank_derr", de_cnt, 1);
    chk("blank_out1", out1, 5'h00);
    chk("blank_vmask", valid_mask, 6'h00);

    // Exactly 1+STABLE_CYC cycles from WAIT captures on the last edge
    drive(6'h3E, 8'h80); tick(4);
    chk("edge_out0_pre", out0, 5'h00);
    tick(1);
    chk("edge_out0", out0, 5'h08);
    chk("edge_vmask", valid_mask, 6'h01);
    drive(6'h3F, 8'hFF); tick(3);

    // Full scan 0..5
    for (int k = 0; k < 5; k++) begin
      drive(sel_of(k), segs[k]); tick(10);
    end
    drive(sel_of(5), segs[5]); tick(5);
    chk("scan_out5_pre", out5, 5'h00);
    tick(1);
    chk("scan_out5", out5, 5'h05);
    chk("scan_fd_pre", frame_done, 1'b0);
    tick(1);
    chk("scan_fd", frame_done, 1'b1);
    tick(1);
    chk("scan_fd_post", frame_done, 1'b0);
    tick(2);
    for (int k = 0; k < 5; k++) chk($sformatf("scan_out%0d", k), out_of(k), 5'(k));
    chk("scan_vmask", valid_mask, 6'h3F);
    chk("scan_fdcnt", fd_cnt, 1);

    // Two cleared select bits is illegal; then a dp-on F on position 2
    drive(6'h3F, 8'hFF); tick(3);
    drive(6'h3C, 8'h80); tick(20);
    chk("multi_fdcnt", fd_cnt, 1);
    chk("multi_derr", de_cnt, 1);
    chk("multi_out2", out2, 5'h02);
    drive(6'h3B, 8'h0E); tick(4);
    chk("dp_out2_pre", out2, 5'h02);
    tick(1);
    chk("dp_out2", out2, 5'h1F);

    // Reset in the middle of counting position 4
    drive(6'h3F, 8'hFF); tick(3);
    drive(6'h2F, 8'h99); tick(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out2", out2, 5'h00);
    chk("mid_rst_out0", out0, 5'h00);
    chk("mid_rst_vmask", valid_mask, 6'h00);
    chk("mid_rst_fdone", frame_done, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("post_rst_out4_pre", out4, 5'h00);
    tick(1);
    chk("post_rst_out4", out4, 5'h04);
    chk("post_rst_vmask", valid_mask, 6'h10);

    // Two continuous frames, position 3 pattern changes while held
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    fd0 = fd_cnt;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 6; k++) begin
        if (k == 3) begin
          drive(sel_of(3), segs[3]); tick(8);
          drive(sel_of(3), 8'h80);   tick(4);
        end else if (k == 0 && f == 1) begin
          drive(sel_of(0), 8'h88); tick(10);
        end else begin
          drive(sel_of(k), segs[k]); tick(10);
        end
      end
      chk($sformatf("fr%0d_out3", f), out3, 5'h03);
      chk($sformatf("fr%0d_fdcnt", f), fd_cnt - fd0, f + 1);
    end
    chk("fr_out0", out0, 5'h0A);
    chk("fr_out5", out5, 5'h05);
    chk("fr_vmask", valid_mask, 6'h3F);
    chk("fr_derr", de_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/led_demux.md
LED_DEMUX -- requirements
Module: led_demux

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4: consecutive cycles a selection must hold before its segment pattern is captured (legal 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port seg_in  input  8  scanned segment bus; [6:0]=g..a active-low, [7]=decimal point active-low.
REQ-005 SHALL have port sel_in  input  6  scanned digit select, active-low one-hot; bit k selects position k.
REQ-006 SHALL have ports out0..out5  output  5 each  recovered digit k; [4]=decimal point (1=lit), [3:0]=hex value.
REQ-007 SHALL have port valid_mask  output  6  bit k set once position k captured at least once since reset.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse when all six positions captured in current frame.
REQ-009 SHALL have port decode_err  output  1  one-cycle pulse when a captured pattern is not in the decode table.

Function
REQ-010 SHALL register seg_in and sel_in once before any use; all latencies below count from this registered copy.
REQ-011 SHALL treat sel as legal only when exactly one bit is 0; all-ones or multiple zeros is illegal.
REQ-012 SHALL run FSM states WAIT, COUNT, HELD.
REQ-013 WAIT: on legal sel, load stable counter to 1, latch sel/seg, go COUNT; otherwise stay.
REQ-014 COUNT: if sel or seg differs from latched value, return to WAIT without capture (no error); else increment counter.
REQ-015 COUNT: in the cycle the counter reaches STABLE_CYC, SHALL capture latched pattern into position k and go HELD.
REQ-016 HELD: stay while sel unchanged (seg changes ignored); any sel change goes to WAIT; no second capture of same selection period.
REQ-017 Decode table (seg[6:0] hex -> value): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-018 On capture with a table hit SHALL update outk[3:0], outk[4]=~seg[7], set valid_mask[k] and frame bit k, in the same cycle.
REQ-019 On capture with a table miss (including blank 7F) SHALL pulse decode_err, leave outk, valid_mask and frame bits unchanged.
REQ-020 SHALL keep a 6-bit frame register; when it becomes all ones, frame_done SHALL pulse the following cycle and the frame register SHALL clear in that same cycle.
REQ-021 A capture coinciding with frame clear SHALL be recorded in the new frame (set wins over clear for that bit).
REQ-022 Re-capturing an already-set frame bit SHALL update outk but not affect frame_done timing.
REQ-023 Stable counter SHALL saturate at STABLE_CYC; no wrap.

Reset
REQ-024 On rst_n low, asynchronously: out0..out5=0, valid_mask=0, frame register=0, frame_done=0, decode_err=0, FSM=WAIT, input registers=all ones.
REQ-025 Reset asserted mid-COUNT SHALL abort capture; first capture after release requires full STABLE_CYC stability.

Verification
REQ-026 Reset then scan positions 0..5 with patterns 40,79,24,30,19,12 (dp off), 10 cycles each -> out0..5 = 0..5, valid_mask=3F, single frame_done pulse one cycle after position-5 capture.
REQ-027 sel_in=3E with seg 00 held 3 cycles then sel changes (STABLE_CYC=4) -> no capture, out0 and valid_mask unchanged, no decode_err.
REQ-028 sel_in=3D, seg_in=7F held 10 cycles -> decode_err pulses exactly once, out1 unchanged, valid_mask[1]=0.
REQ-029 sel_in=3C (two zeros) held 20 cycles -> no capture, no pulses; then sel_in=3B with seg_in=0E (dp on, seg[7]=0) -> out2=1F after 1+STABLE_CYC cycles.
REQ-030 Assert rst_n low during COUNT of position 4 -> all outputs 0 immediately; after release same stimulus captures only after full STABLE_CYC.
REQ-031 Continuous two-frame scan with digit 3 pattern changed mid-HELD -> out3 keeps first captured value; frame_done pulses once per frame.
